// File: rtl/act_pkg.sv
// Shared types for the activation pipeline: activation mode encoding, statistics width
// and a saturating adder for the statistics counters.
package act_pkg;

   typedef enum logic [1:0] {
      ACT_RELU  = 2'd0,
      ACT_LEAKY = 2'd1,
      ACT_CLIP  = 2'd2,
      ACT_PASS  = 2'd3
   } act_mode_e;

   localparam int STAT_W = 32;

   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [STAT_W-1:0] b);
      logic [STAT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/act_pipeline_lane.sv
// Single-lane combinational activation: ReLU, leaky ReLU, clipped ReLU or pass-through,
// plus the per-lane negative/clipped flags used by the statistics counters.
module act_lane
   import act_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic signed [DATA_WIDTH-1:0] i_x,
   input  act_mode_e                    i_mode,
   input  logic        [3:0]            i_shift,
   input  logic signed [DATA_WIDTH-1:0] i_clip,
   output logic        [DATA_WIDTH-1:0] o_y,
   output logic                         o_neg,
   output logic                         o_clipped
);

   logic signed [DATA_WIDTH-1:0] w_relu;
   logic signed [DATA_WIDTH-1:0] w_clip_eff;
   logic signed [DATA_WIDTH-1:0] w_leaky;
   logic                         w_over;

   always_comb begin
      o_neg      = i_x[DATA_WIDTH-1];
      w_relu     = o_neg ? '0 : i_x;
      // A negative bound degenerates to zero, so every CLIP output is 0.
      w_clip_eff = i_clip[DATA_WIDTH-1] ? '0 : i_clip;
      w_over     = w_relu > w_clip_eff;
      w_leaky    = o_neg ? (i_x >>> i_shift) : i_x;
      o_clipped  = (i_mode == ACT_CLIP) && w_over;
      o_y        = i_x;
      case (i_mode)
         ACT_RELU:  o_y = w_relu;
         ACT_LEAKY: o_y = w_leaky;
         ACT_CLIP:  o_y = w_over ? w_clip_eff : w_relu;
         ACT_PASS:  o_y = i_x;
         default:   o_y = i_x;
      endcase
   end

endmodule

// File: rtl/act_pipeline.sv
// Multi-lane activation stage with an elastic valid/ready register pipeline.
// Optional feature macro ACT_PIPE_STATS_EN adds per-lane negative/clip delivery counters.
module act_pipeline
   import act_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int STAGES     = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  cfg_mode,
   input  logic [3:0]                  cfg_leak_shift,
   input  logic [DATA_WIDTH-1:0]       cfg_clip,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [LANES*DATA_WIDTH-1:0] s_data,
   output logic                        m_valid,
   input  logic                        m_ready,
`ifdef ACT_PIPE_STATS_EN
   input  logic                        stat_clr,
   output logic [STAT_W-1:0]           stat_neg_cnt,
   output logic [STAT_W-1:0]           stat_clip_cnt,
`endif
   output logic [LANES*DATA_WIDTH-1:0] m_data
);

   localparam int DW = LANES * DATA_WIDTH;

   logic [DW-1:0]    w_lane_y;
   logic [LANES-1:0] w_neg;
   logic [LANES-1:0] w_clp;
   logic [STAGES:0]  w_ready;

   logic [STAGES-1:0] r_valid;
   logic [DW-1:0]     r_data [STAGES];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      act_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .i_x       (s_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .i_mode    (act_mode_e'(cfg_mode)),
         .i_shift   (cfg_leak_shift),
         .i_clip    (cfg_clip),
         .o_y       (w_lane_y[g*DATA_WIDTH +: DATA_WIDTH]),
         .o_neg     (w_neg[g]),
         .o_clipped (w_clp[g])
      );
   end

   // Stage i can advance if m_ready is high or any stage from i to the output is empty.
   assign w_ready[STAGES] = m_ready;
   for (genvar s = 0; s < STAGES; s++) begin : g_ready
      assign w_ready[s] = m_ready | ~(&r_valid[STAGES-1:s]);
   end

   assign s_ready = w_ready[0] & rst_n;
   assign m_valid = r_valid[STAGES-1];
   assign m_data  = r_data[STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
      end else begin
         if (w_ready[0]) begin
            r_valid[0] <= s_valid;
            if (s_valid) r_data[0] <= w_lane_y;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (w_ready[i]) begin
               r_valid[i] <= r_valid[i-1];
               if (r_valid[i-1]) r_data[i] <= r_data[i-1];
            end
         end
      end
   end

`ifdef ACT_PIPE_STATS_EN
   logic [LANES-1:0]  r_neg [STAGES];
   logic [LANES-1:0]  r_clp [STAGES];
   logic [STAT_W-1:0] r_neg_cnt;
   logic [STAT_W-1:0] r_clip_cnt;
   logic [STAT_W-1:0] w_neg_add;
   logic [STAT_W-1:0] w_clp_add;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_neg[i] <= '0;
            r_clp[i] <= '0;
         end
      end else begin
         if (w_ready[0] && s_valid) begin
            r_neg[0] <= w_neg;
            r_clp[0] <= w_clp;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (w_ready[i] && r_valid[i-1]) begin
               r_neg[i] <= r_neg[i-1];
               r_clp[i] <= r_clp[i-1];
            end
         end
      end
   end

   always_comb begin
      w_neg_add = '0;
      w_clp_add = '0;
      for (int l = 0; l < LANES; l++) begin
         w_neg_add = w_neg_add + STAT_W'(r_neg[STAGES-1][l]);
         w_clp_add = w_clp_add + STAT_W'(r_clp[STAGES-1][l]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg_cnt  <= '0;
         r_clip_cnt <= '0;
      end else if (stat_clr) begin
         r_neg_cnt  <= '0;
         r_clip_cnt <= '0;
      end else if (m_valid && m_ready) begin
         r_neg_cnt  <= sat_add(r_neg_cnt, w_neg_add);
         r_clip_cnt <= sat_add(r_clip_cnt, w_clp_add);
      end
   end

   assign stat_neg_cnt  = r_neg_cnt;
   assign stat_clip_cnt = r_clip_cnt;
`else
   logic w_flags_unused;
   assign w_flags_unused = ^{w_neg, w_clp};
`endif

endmodule
